// File: rtl/arb_pkg.sv
// Shared types and helpers for the request/grant arbiter.
package arb_pkg;
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam int RR    = 0;
   localparam int FIXED = 1;

   // Index width for n items, never narrower than one bit.
   function automatic int clog2w(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// Masked rotating priority encoder: first unmasked request at or after the pointer,
// or the lowest unmasked index when i_mode is set.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   i_req,
   input  logic [IDW-1:0] i_ptr,
   input  logic [N-1:0]   i_mask,
   input  logic           i_mode,
   output logic [N-1:0]   o_win,
   output logic [IDW-1:0] o_idx,
   output logic           o_any
);
   logic [N-1:0] w_req;

   assign w_req = i_req & ~i_mask;

   always_comb begin
      int   pos;
      logic found;
      o_win = '0;
      o_idx = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         pos = i_mode ? k : ((int'(i_ptr) + k) % N);
         if (!found && w_req[pos]) begin
            o_win[pos] = 1'b1;
            o_idx      = IDW'(pos);
            found      = 1'b1;
         end
      end
      o_any = found;
   end
endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter with registered one-hot grant, grant hold while requested,
// and an optional hold limit that force-releases the owner.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int MAX_HOLD  = 8,
   parameter int PRIO_MODE = RR,
   localparam int ID_W     = clog2w(N_REQ)
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [N_REQ-1:0] i_req,
   output logic [N_REQ-1:0] o_grant,
   output logic [ID_W-1:0]  o_grant_id,
   output logic             o_grant_valid,
   output logic             o_timeout
);
   localparam int CNT_W = clog2w((MAX_HOLD < 2) ? 2 : MAX_HOLD);

   state_t           r_state;
   logic [N_REQ-1:0] r_grant;
   logic [ID_W-1:0]  r_id;
   logic             r_valid;
   logic             r_timeout;
   logic [ID_W-1:0]  r_ptr;
   logic [CNT_W-1:0] r_cnt;

   logic             w_own_req;
   logic             w_tmo;
   logic [ID_W-1:0]  w_ptr_nxt;
   logic [ID_W-1:0]  w_pick_ptr;
   logic [N_REQ-1:0] w_mask;
   logic [N_REQ-1:0] w_win;
   logic [ID_W-1:0]  w_idx;
   logic             w_any;

   assign w_own_req  = |(i_req & r_grant);
   assign w_tmo      = (MAX_HOLD != 0) && (r_cnt == CNT_W'(MAX_HOLD - 1));
   assign w_ptr_nxt  = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);
   // While granted, any re-arbitration starts just past the current owner.
   assign w_pick_ptr = (r_state == GRANT) ? w_ptr_nxt : r_ptr;
   assign w_mask     = (r_state == GRANT && w_own_req && w_tmo) ? r_grant : '0;

   rr_pick #(.N(N_REQ), .IDW(ID_W)) u_pick (
      .i_req  (i_req),
      .i_ptr  (w_pick_ptr),
      .i_mask (w_mask),
      .i_mode (PRIO_MODE == FIXED),
      .o_win  (w_win),
      .o_idx  (w_idx),
      .o_any  (w_any)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_id      <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         r_ptr     <= '0;
         r_cnt     <= '0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: if (w_any) begin
               r_state <= GRANT;
               r_grant <= w_win;
               r_id    <= w_idx;
               r_valid <= 1'b1;
               r_cnt   <= '0;
            end
            GRANT: begin
               if (!w_own_req) begin
                  r_ptr <= w_ptr_nxt;
                  r_cnt <= '0;
                  if (w_any) begin
                     r_grant <= w_win;
                     r_id    <= w_idx;
                  end else begin
                     r_state <= IDLE;
                     r_grant <= '0;
                     r_id    <= '0;
                     r_valid <= 1'b0;
                  end
               end else if (w_tmo) begin
                  // Sole requester finds nothing after masking and keeps its grant.
                  r_ptr     <= w_ptr_nxt;
                  r_timeout <= 1'b1;
                  r_cnt     <= '0;
                  if (w_any) begin
                     r_grant <= w_win;
                     r_id    <= w_idx;
                  end
               end else if (MAX_HOLD != 0 || r_cnt != '1) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_grant       = r_grant;
   assign o_grant_id    = r_id;
   assign o_grant_valid = r_valid;
   assign o_timeout     = r_timeout;

   a_onehot: assert property (@(posedge i_clock) disable iff (i_reset) $onehot0(r_grant));
   a_valid:  assert property (@(posedge i_clock) disable iff (i_reset) r_valid == |r_grant);
   a_req:    assert property (@(posedge i_clock) disable iff (i_reset)
                              |r_grant |-> |($past(i_req) & r_grant));
endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench: a round-robin instance with hold limit 4, and a fixed-priority
// instance with no hold limit.
module tb_rr_arbiter;
   typedef struct {
      logic [3:0] g;
      logic       t;
      string      nm;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] reqA, reqB;
   logic [3:0] gA, gB;
   logic [1:0] idA, idB;
   logic       vA, vB, tA, tB;

   exp_t qA[$];
   exp_t qB[$];
   exp_t eA, eB;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   rr_arbiter #(.N_REQ(4), .MAX_HOLD(4), .PRIO_MODE(0)) uA (
      .i_clock(clk), .i_reset(rst), .i_req(reqA),
      .o_grant(gA), .o_grant_id(idA), .o_grant_valid(vA), .o_timeout(tA)
   );

   rr_arbiter #(.N_REQ(4), .MAX_HOLD(0), .PRIO_MODE(1)) uB (
      .i_clock(clk), .i_reset(rst), .i_req(reqB),
      .o_grant(gB), .o_grant_id(idB), .o_grant_valid(vB), .o_timeout(tB)
   );

   function automatic logic [1:0] idx_of(input logic [3:0] g);
      logic [1:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
      return r;
   endfunction

   task automatic check(input string nm, input logic [3:0] ag, input logic av,
                        input logic [1:0] aid, input logic at,
                        input logic [3:0] eg, input logic et);
      logic       ev;
      logic [1:0] eid;
      ev  = |eg;
      eid = idx_of(eg);
      n_cmp++;
      if (ag !== eg || av !== ev || at !== et || (ev && aid !== eid)) begin
         n_bad++;
         $display("FAIL %s: got grant=%b valid=%b id=%0d timeout=%b, want grant=%b valid=%b id=%0d timeout=%b",
                  nm, ag, av, aid, at, eg, ev, eid, et);
      end
   endtask

   task automatic stepA(input logic [3:0] r, input logic [3:0] g, input logic t, input string nm);
      @(negedge clk);
      reqA = r;
      qA.push_back('{g, t, nm});
   endtask

   task automatic stepB(input logic [3:0] r, input logic [3:0] g, input string nm);
      @(negedge clk);
      reqB = r;
      qB.push_back('{g, 1'b0, nm});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      reqA = '0;
      reqB = '0;
      @(negedge clk);
      rst  = 1'b0;
   endtask

   // Monitor: one expectation per edge, compared just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (qA.size() > 0) begin
            eA = qA.pop_front();
            check(eA.nm, gA, vA, idA, tA, eA.g, eA.t);
         end
         if (qB.size() > 0) begin
            eB = qB.pop_front();
            check(eB.nm, gB, vB, idB, tB, eB.g, eB.t);
         end
      end
   end

   initial begin
      rst  = 1'b1;
      reqA = '0;
      reqB = '0;
      repeat (2) @(negedge clk);
      check("reset_A", gA, vA, idA, tA, 4'b0000, 1'b0);
      check("reset_B", gB, vB, idB, tB, 4'b0000, 1'b0);
      rst = 1'b0;

      // Reset mid-grant, then a fresh request is served one cycle later.
      stepA(4'b0001, 4'b0001, 1'b0, "rst_pre0");
      stepA(4'b0001, 4'b0001, 1'b0, "rst_pre1");
      @(negedge clk);
      rst = 1'b1;
      #1 check("rst_async", gA, vA, idA, tA, 4'b0000, 1'b0);
      stepA(4'b0001, 4'b0000, 1'b0, "rst_hold");
      @(negedge clk);
      rst  = 1'b0;
      reqA = 4'b0010;
      qA.push_back('{4'b0010, 1'b0, "rst_after"});
      stepA(4'b0000, 4'b0000, 1'b0, "rst_rel");

      // Round-robin rotation with no idle gap between owners.
      do_reset();
      stepA(4'b1111, 4'b0001, 1'b0, "rot_0a");
      stepA(4'b1111, 4'b0001, 1'b0, "rot_0b");
      stepA(4'b1110, 4'b0010, 1'b0, "rot_1a");
      stepA(4'b1111, 4'b0010, 1'b0, "rot_1b");
      stepA(4'b1101, 4'b0100, 1'b0, "rot_2a");
      stepA(4'b1111, 4'b0100, 1'b0, "rot_2b");
      stepA(4'b1011, 4'b1000, 1'b0, "rot_3a");
      stepA(4'b1111, 4'b1000, 1'b0, "rot_3b");
      stepA(4'b0111, 4'b0001, 1'b0, "rot_wrap");
      stepA(4'b0000, 4'b0000, 1'b0, "rot_idle");

      // Timeout hands the grant back and forth between two holders.
      do_reset();
      for (int i = 0; i < 4; i++) stepA(4'b0011, 4'b0001, 1'b0, "tmo_own0");
      stepA(4'b0011, 4'b0010, 1'b1, "tmo_to1");
      for (int i = 0; i < 3; i++) stepA(4'b0011, 4'b0010, 1'b0, "tmo_own1");
      stepA(4'b0011, 4'b0001, 1'b1, "tmo_to0");
      stepA(4'b0011, 4'b0001, 1'b0, "tmo_hold0");
      stepA(4'b0000, 4'b0000, 1'b0, "tmo_idle");

      // Sole requester is re-granted on timeout without dropping grant.
      do_reset();
      for (int i = 0; i < 4; i++) stepA(4'b0100, 4'b0100, 1'b0, "sole_a");
      stepA(4'b0100, 4'b0100, 1'b1, "sole_tmo1");
      for (int i = 0; i < 3; i++) stepA(4'b0100, 4'b0100, 1'b0, "sole_b");
      stepA(4'b0100, 4'b0100, 1'b1, "sole_tmo2");
      stepA(4'b0000, 4'b0000, 1'b0, "sole_idle");

      // Release in the same cycle the hold limit is reached: no timeout pulse.
      do_reset();
      for (int i = 0; i < 4; i++) stepA(4'b0101, 4'b0001, 1'b0, "sim_own0");
      stepA(4'b0100, 4'b0100, 1'b0, "sim_rel");
      stepA(4'b0000, 4'b0000, 1'b0, "sim_idle");

      // Fixed priority, no hold limit.
      do_reset();
      stepB(4'b1010, 4'b0010, "fix_1010");
      stepB(4'b1010, 4'b0010, "fix_hold");
      stepB(4'b1001, 4'b0001, "fix_1001");
      for (int i = 0; i < 6; i++) stepB(4'b1001, 4'b0001, "fix_nolimit");
      stepB(4'b1000, 4'b1000, "fix_1000");
      stepB(4'b0000, 4'b0000, "fix_idle");

      for (int k = 0; k < 20 && (qA.size() + qB.size()) > 0; k++) @(posedge clk);
      #2;
      if ((qA.size() + qB.size()) > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", qA.size() + qB.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
